// File: rtl/blockram_port_master.sv
// Request/response master for one port of a 1-cycle-latency, no-change-mode block RAM.
// Optional multi-beat bursts with address wrap are enabled by defining BLOCKRAM_MASTER_BURST_EN.
module blockram_port_master #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 32,
    parameter int WRITE_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    input  logic [DATA_WIDTH/WRITE_WIDTH-1:0]   req_be,
`ifdef BLOCKRAM_MASTER_BURST_EN
    input  logic [7:0]                          req_len,
`endif
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_last,
    output logic                                ram_ena,
    output logic [DATA_WIDTH/WRITE_WIDTH-1:0]   ram_we,
    output logic [ADDR_WIDTH-1:0]               ram_addr,
    output logic [DATA_WIDTH-1:0]               ram_din,
    input  logic [DATA_WIDTH-1:0]               ram_dout
);

    localparam int NB = DATA_WIDTH / WRITE_WIDTH;

`ifdef BLOCKRAM_MASTER_BURST_EN
    typedef enum logic {S_IDLE, S_BURST} state_t;
`else
    typedef enum logic {S_IDLE} state_t;
`endif

    state_t state, state_next;
    logic   accept;
    logic   read_issue;

`ifdef BLOCKRAM_MASTER_BURST_EN
    logic                  beat_issue;
    logic                  issue_last;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [7:0]            burst_left;
    logic                  burst_write;
    logic [DATA_WIDTH-1:0] burst_wdata;
    logic [NB-1:0]         burst_be;
`endif

    // The RAM holds its output on non-read cycles, so read data needs no local register.
    assign rsp_rdata = ram_dout;

    // NOTE: every output of this block is assigned a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        read_issue = 1'b0;
        ram_ena    = 1'b0;
        ram_we     = '0;
        ram_addr   = req_addr;
        ram_din    = req_wdata;
`ifdef BLOCKRAM_MASTER_BURST_EN
        beat_issue = 1'b0;
        issue_last = 1'b1;
`endif
        case (state)
            S_IDLE: begin
                // A read may only issue when its response slot is free or draining this cycle.
                req_ready = rst_n && (req_write || !rsp_valid || rsp_ready);
                accept    = req_valid && req_ready;
                if (accept) begin
                    ram_ena    = !req_write || (|req_be);
                    ram_we     = req_write ? req_be : '0;
                    read_issue = !req_write;
`ifdef BLOCKRAM_MASTER_BURST_EN
                    issue_last = (req_len == 8'd0);
                    if (req_len != 8'd0)
                        state_next = S_BURST;
`endif
                end
            end
`ifdef BLOCKRAM_MASTER_BURST_EN
            S_BURST: begin
                ram_addr = burst_addr;
                ram_din  = burst_wdata;
                if (burst_write || !rsp_valid || rsp_ready) begin
                    beat_issue = 1'b1;
                    ram_ena    = !burst_write || (|burst_be);
                    ram_we     = burst_write ? burst_be : '0;
                    read_issue = !burst_write;
                    issue_last = (burst_left == 8'd1);
                    if (burst_left == 8'd1)
                        state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments with the asynchronous reset branch first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (read_issue)
                rsp_valid <= 1'b1;
            else if (rsp_ready)
                rsp_valid <= 1'b0;
        end
    end

`ifdef BLOCKRAM_MASTER_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b0;
            burst_addr  <= '0;
            burst_left  <= '0;
            burst_write <= 1'b0;
        end else begin
            if (read_issue)
                last_q <= issue_last;
            if (accept && req_len != 8'd0) begin
                burst_addr  <= req_addr + 1'b1;
                burst_left  <= req_len;
                burst_write <= req_write;
            end else if (beat_issue) begin
                burst_addr <= burst_addr + 1'b1;
                burst_left <= burst_left - 1'b1;
            end
        end
    end

    // NOTE: payload registers are only read while in BURST, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept && req_len != 8'd0) begin
            burst_wdata <= req_wdata;
            burst_be    <= req_be;
        end
    end

    assign rsp_last = rsp_valid && last_q;
`else
    assign rsp_last = rsp_valid;
`endif

endmodule
